// File: rtl/flit_credit_rx_buffer.sv
// Receive-side credit-based flit buffer with FWFT output stream.
// Returns one credit per dequeued flit and flags protocol violations.
module flit_credit_rx_buffer #(
  parameter int DATA_WIDTH  = 128,
  parameter int TDEST_WIDTH = 3,
  parameter int DEPTH       = 4
) (
  input  logic                       clk_noc,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic [TDEST_WIDTH-1:0]     dest_in,
  input  logic                       is_tail_in,
  input  logic                       send_in,
  output logic                       credit_out,
  output logic                       flit_valid_out,
  input  logic                       flit_ready_in,
  output logic [DATA_WIDTH-1:0]      flit_data_out,
  output logic [TDEST_WIDTH-1:0]     flit_dest_out,
  output logic                       flit_is_tail_out,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       overflow_err,
  output logic                       dest_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0]  data_mem [DEPTH];
  logic [TDEST_WIDTH-1:0] dest_mem [DEPTH];
  logic                   tail_mem [DEPTH];

  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   credit_q;
  logic                   ovf_q, ovf_d;
  logic                   derr_q, derr_d;
  logic                   in_pkt_q, in_pkt_d;
  logic [TDEST_WIDTH-1:0] pkt_dest_q, pkt_dest_d;

  logic full;
  logic deq;
  logic wr;

  assign full = (count_q == CW'(DEPTH));
  assign flit_valid_out = (count_q != '0);
  assign deq = flit_valid_out & flit_ready_in;
  // A full buffer still accepts when a slot frees at the same edge
  assign wr = send_in & (~full | deq);

  // Head entry drives outputs; gated to zero when empty
  always_comb begin
    flit_data_out    = '0;
    flit_dest_out    = '0;
    flit_is_tail_out = 1'b0;
    if (flit_valid_out) begin
      flit_data_out    = data_mem[rd_ptr_q];
      flit_dest_out    = dest_mem[rd_ptr_q];
      flit_is_tail_out = tail_mem[rd_ptr_q];
    end
  end

  // Next-state for pointers, fill count, packet tracking and flags
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    derr_d     = derr_q;
    in_pkt_d   = in_pkt_q;
    pkt_dest_d = pkt_dest_q;
    if (wr) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      in_pkt_d = ~is_tail_in;
      if (!in_pkt_q) begin
        pkt_dest_d = dest_in;
      end else if (dest_in != pkt_dest_q) begin
        derr_d = 1'b1;
      end
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (send_in && !wr) begin
      ovf_d = 1'b1;
    end
    unique case (1'b1)
      (wr && !deq): count_d = count_q + CW'(1);
      (!wr && deq): count_d = count_q - CW'(1);
      default:      count_d = count_q;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      credit_q   <= 1'b0;
      ovf_q      <= 1'b0;
      derr_q     <= 1'b0;
      in_pkt_q   <= 1'b0;
      pkt_dest_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      credit_q   <= deq;
      ovf_q      <= ovf_d;
      derr_q     <= derr_d;
      in_pkt_q   <= in_pkt_d;
      pkt_dest_q <= pkt_dest_d;
    end
  end

  // Flit storage; contents need no reset since outputs are gated
  always_ff @(posedge clk_noc) begin
    if (wr) begin
      data_mem[wr_ptr_q] <= data_in;
      dest_mem[wr_ptr_q] <= dest_in;
      tail_mem[wr_ptr_q] <= is_tail_in;
    end
  end

  assign credit_out   = credit_q;
  assign occupancy    = count_q;
  assign overflow_err = ovf_q;
  assign dest_err     = derr_q;

endmodule

// File: doc/flit_credit_rx_buffer.md
Name: flit_credit_rx_buffer

Overview:
- Receive-side flit buffer on the NoC clock domain.
- Directly downstream of the serializer shim's flit output (data/dest/is_tail/send, credit return). Sits in front of a router input port or a deserializer shim.
- Stores up to DEPTH flits and presents them as a first-word-fall-through valid/ready stream.
- Returns one credit per dequeued flit. Flags protocol violations: overflow, and dest change inside a packet.

Parameters:
- DATA_WIDTH, 128, flit payload width in bits.
- TDEST_WIDTH, 3, destination field width.
- DEPTH, 4, flit slots; power of two, >= 2. Upstream credit counter resets to this value.

Ports:
- clk_noc  input  1  NoC clock.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  DATA_WIDTH  flit payload from upstream.
- dest_in  input  TDEST_WIDTH  flit destination.
- is_tail_in  input  1  flit is last of packet.
- send_in  input  1  flit present this cycle; no backpressure.
- credit_out  output  1  one-cycle pulse; returns one buffer slot to upstream.
- flit_valid_out  output  1  head-of-queue flit valid.
- flit_ready_in  input  1  downstream accepts head flit.
- flit_data_out  output  DATA_WIDTH  head flit payload.
- flit_dest_out  output  TDEST_WIDTH  head flit destination.
- flit_is_tail_out  output  1  head flit tail marker.
- occupancy  output  $clog2(DEPTH)+1  flits currently stored.
- overflow_err  output  1  sticky: flit arrived with no free slot.
- dest_err  output  1  sticky: body/tail dest differs from packet head dest.

Behaviour:
- Reset (async assert, sync deassert by upstream):
  - credit_out=0, flit_valid_out=0, occupancy=0, overflow_err=0, dest_err=0.
  - Read/write pointers = 0; in_packet=0.
  - flit_data/dest/is_tail outputs = 0.
- Storage: circular buffer of DEPTH entries {data, dest, is_tail}.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - Count register tracks fill level.
- Write: on a posedge with send_in=1 and a free slot, the flit is stored at wr_ptr and wr_ptr increments.
  - A slot is free when count<DEPTH, or count==DEPTH with a dequeue at the same edge.
- Latency: a flit written at edge t is visible on flit_valid_out/flit_*_out from edge t (registered; visible the cycle after send_in). Flit outputs are driven combinationally from the head entry.
- Dequeue: handshake = flit_valid_out & flit_ready_in at a posedge; rd_ptr increments.
  - flit_*_out must hold stable while valid and not ready.
- Credit: credit_out is registered and asserted for exactly the one cycle following each dequeue edge.
  - Back-to-back dequeues give back-to-back pulses.
  - Exactly one pulse per dequeued flit; never pulses otherwise.
- Simultaneous write and dequeue: count unchanged. Legal at any count, including full and including empty→write+nothing to read (no bypass; empty buffer never dequeues).
- Overflow: send_in=1 while count==DEPTH and no dequeue at that edge.
  - Flit dropped; contents and pointers untouched.
  - overflow_err sets and stays set until reset.
- Packet tracking (write side):
  - in_packet=0: accepted flit is a head; its dest is latched as pkt_dest.
  - in_packet becomes 1 if is_tail_in=0; single-flit packet (head with is_tail_in=1) leaves in_packet=0.
  - in_packet=1: accepted flit with dest_in≠pkt_dest sets dest_err (sticky). Flit is still stored.
  - Tail clears in_packet.
  - Dropped (overflow) flits do not update tracking.
- occupancy = count, registered, updated at the same edge as pointers.
- Reset mid-operation:
  - Buffer contents discarded; pointers, count and flags clear.
  - In-flight credit pulse is cancelled.
  - Upstream is reset by the same rst_n and restores DEPTH credits.

Test Plan:
- Reset then idle → all outputs 0, occupancy=0, no credit pulses over 10 cycles.
- Single flit data=128'h1, dest=2, tail=1, ready=1 → valid 1 cycle after send; dequeued; credit_out high exactly one cycle after dequeue edge; occupancy back to 0.
- ready=0, send 4 flits data 1..4 → occupancy=4, flit_data_out held at 1, no credits. Then ready=1 for 4 cycles → data 1,2,3,4 in order; 4 consecutive credit pulses.
- Full (4 flits) and a 5th send with ready=0 → overflow_err=1 sticky, occupancy=4, data 1..4 unchanged. Repeat with ready=1 on same edge → 5th flit accepted, no error.
- Packet head dest=3, tail=0; body dest=5 → dest_err=1, both flits delivered. Next packet: dest=5 head with tail=1 → no further change.
- Assert rst_n=0 with occupancy=3 and a credit pulse pending → outputs immediately 0, no pulse after release, next send accepted at slot 0.
